// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding plus frame helpers.
// Imported by uart_rx; frame_len is also used by uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_t;

  // Bits on the wire for one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned frame_bits,
                                            input int unsigned parity_bit,
                                            input int unsigned stop_bits);
    return 32'd1 + frame_bits + ((parity_bit < 32'd2) ? 32'd1 : 32'd0) + stop_bits;
  endfunction

  // Even-sum parity of a word (zero-extend narrower words).
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta_r;

  // Double-register the pin into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      meta_r <= rx;
      rx_s   <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first reassembly,
// parity/stop checking and a one-cycle rx_done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int PARITY_BIT = 2,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] data,
  output logic                  rx_done,
  output logic                  rx_busy,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(FRAME_BITS) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY_BIT < 2);

  logic                  rx_s;
  uart_state_t           state_r, state_next_s;
  logic [CW-1:0]         cnt_r, cnt_next_s;
  logic [IW-1:0]         bit_idx_r, bit_idx_next_s;
  logic [FRAME_BITS-1:0] shift_r, shift_next_s;
  logic                  par_err_r, par_err_next_s;
  logic                  fr_err_r, fr_err_next_s;
  logic                  armed_r, armed_next_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      bit_idx_r     <= '0;
      shift_r       <= '0;
      par_err_r     <= 1'b0;
      fr_err_r      <= 1'b0;
      armed_r       <= 1'b1;
      data          <= '0;
      rx_done       <= 1'b0;
      rx_busy       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      par_err_r <= par_err_next_s;
      fr_err_r  <= fr_err_next_s;
      armed_r   <= armed_next_s;
      rx_busy   <= (state_next_s != ST_IDLE);
      rx_done   <= (state_next_s == ST_DONE);
      // Outputs are loaded on entry to DONE so they are valid alongside rx_done.
      if (state_next_s == ST_DONE) begin
        data          <= shift_next_s;
        parity_error  <= par_err_next_s;
        framing_error <= fr_err_next_s;
      end else begin
        data          <= data;
        parity_error  <= parity_error;
        framing_error <= framing_error;
      end
    end
  end

  // Next-state decision.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !rx_s) state_next_s = ST_START;
        else                  state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) state_next_s = rx_s ? ST_IDLE : ST_DATA;
        else                   state_next_s = ST_START;
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST && bit_idx_r == BIT_LAST)
          state_next_s = HAS_PARITY ? ST_PARITY : ST_STOP;
        else
          state_next_s = ST_DATA;
      end
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) state_next_s = ST_STOP;
        else                   state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST && bit_idx_r == STOP_LAST) state_next_s = ST_DONE;
        else                                             state_next_s = ST_STOP;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Counters, shift register, error accumulation and re-arm logic.
  always_comb begin
    cnt_next_s     = cnt_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    par_err_next_s = par_err_r;
    fr_err_next_s  = fr_err_r;
    armed_next_s   = armed_r;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s     = '0;
        bit_idx_next_s = '0;
        if (rx_s) armed_next_s = 1'b1;
        else      armed_next_s = armed_r;
        if (armed_r && !rx_s) begin
          par_err_next_s = 1'b0;
          fr_err_next_s  = 1'b0;
        end else begin
          par_err_next_s = par_err_r;
          fr_err_next_s  = fr_err_r;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_next_s     = '0;
          bit_idx_next_s = '0;
        end else begin
          cnt_next_s     = cnt_r + CW'(1'b1);
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s   = '0;
          shift_next_s = {rx_s, shift_r[FRAME_BITS-1:1]};
          if (bit_idx_r == BIT_LAST) bit_idx_next_s = '0;
          else                       bit_idx_next_s = bit_idx_r + IW'(1'b1);
        end else begin
          cnt_next_s = cnt_r + CW'(1'b1);
        end
      end
      ST_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s     = '0;
          par_err_next_s = (rx_s != even_parity(32'(shift_r)));
        end else begin
          cnt_next_s     = cnt_r + CW'(1'b1);
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s     = '0;
          bit_idx_next_s = bit_idx_r + IW'(1'b1);
          if (!rx_s) fr_err_next_s = 1'b1;
          else       fr_err_next_s = fr_err_r;
        end else begin
          cnt_next_s = cnt_r + CW'(1'b1);
        end
      end
      ST_DONE: begin
        cnt_next_s     = '0;
        bit_idx_next_s = '0;
        // A low stop bit may be a break; wait for the line to go high first.
        if (fr_err_r) armed_next_s = 1'b0;
        else          armed_next_s = armed_r;
      end
      default: begin
        cnt_next_s     = '0;
        bit_idx_next_s = '0;
        armed_next_s   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8-bit parity receiver, each fed by
// a behavioural serial driver; received frames are checked against a frame model.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       done_a, busy_a, perr_a, ferr_a;
  logic       done_b, busy_b, perr_b, ferr_b;

  uart_rx dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .rx_done(done_a),
    .rx_busy(busy_a), .parity_error(perr_a), .framing_error(ferr_a)
  );

  uart_rx #(.FRAME_BITS(8), .PARITY_BIT(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .rx_done(done_b),
    .rx_busy(busy_b), .parity_error(perr_b), .framing_error(ferr_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int ncount = 0;
  ev_t qa[$];
  ev_t qb[$];
  int  ta[$];

  // Negedge monitor: timestamps and records every rx_done pulse.
  always @(negedge clk) begin
    ncount = ncount + 1;
    if (done_a) begin
      qa.push_back({data_a, perr_a, ferr_a});
      ta.push_back(ncount);
    end
    if (done_b) qb.push_back({data_b, perr_b, ferr_b});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what a frame on the wire must produce.
  function automatic ev_t model(input logic [7:0] d, input int has_par,
                                input logic pbit, input logic sbit);
    ev_t e;
    e.d  = d;
    e.pe = (has_par != 0) ? (pbit != (^d)) : 1'b0;
    e.fe = ~sbit;
    return e;
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drives one frame, 16 cycles per bit; the line is left at the stop level.
  task automatic send(input int which, input logic [7:0] d, input int has_par,
                      input logic pbit, input logic sbit, output int t0);
    @(negedge clk);
    #1;
    t0 = ncount;
    set_rx(which, 1'b0);
    hold(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      hold(16);
    end
    if (has_par != 0) begin
      set_rx(which, pbit);
      hold(16);
    end
    set_rx(which, sbit);
    hold(16);
  endtask

  task automatic check_next(input string name, input int which, input ev_t exp, output int t);
    ev_t got;
    t = -1;
    if (which == 0) begin
      check({name, " present"}, 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        got = qa.pop_front();
        t   = ta.pop_front();
        check(name, 32'(got), 32'(exp));
      end
    end else begin
      check({name, " present"}, 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        got = qb.pop_front();
        check(name, 32'(got), 32'(exp));
      end
    end
  endtask

  initial begin
    vec_t tbl[6];
    ev_t  last_a;
    ev_t  e;
    int   t0, t;
    logic [7:0] d;
    logic pb, sb;

    tbl[0] = '{d: 8'h07, pbit: 1'b1, sbit: 1'b1, exp_d: 8'h07, exp_pe: 1'b0, exp_fe: 1'b0};
    tbl[1] = '{d: 8'h07, pbit: 1'b0, sbit: 1'b1, exp_d: 8'h07, exp_pe: 1'b1, exp_fe: 1'b0};
    tbl[2] = '{d: 8'h00, pbit: 1'b0, sbit: 1'b1, exp_d: 8'h00, exp_pe: 1'b0, exp_fe: 1'b0};
    tbl[3] = '{d: 8'h00, pbit: 1'b1, sbit: 1'b1, exp_d: 8'h00, exp_pe: 1'b1, exp_fe: 1'b0};
    tbl[4] = '{d: 8'hFF, pbit: 1'b0, sbit: 1'b0, exp_d: 8'hFF, exp_pe: 1'b0, exp_fe: 1'b1};
    tbl[5] = '{d: 8'h81, pbit: 1'b1, sbit: 1'b1, exp_d: 8'h81, exp_pe: 1'b1, exp_fe: 1'b0};

    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(2);
    check("reset data_a", 32'(data_a), 32'd0);
    check("reset flags_a", {28'd0, done_a, busy_a, perr_a, ferr_a}, 32'd0);
    check("reset flags_b", {28'd0, done_b, busy_b, perr_b, ferr_b}, 32'd0);

    // 0xA5 8N1 with latency check.
    send(0, 8'hA5, 0, 1'b0, 1'b1, t0);
    hold(20);
    check("a5 pulses", 32'(qa.size()), 32'd1);
    check_next("a5 frame", 0, '{d: 8'hA5, pe: 1'b0, fe: 1'b0}, t);
    check("a5 latency", 32'(t - t0), 32'd155);

    // Back-to-back frames, no idle gap.
    send(0, 8'h00, 0, 1'b0, 1'b1, t0);
    send(0, 8'hFF, 0, 1'b0, 1'b1, t0);
    send(0, 8'h3C, 0, 1'b0, 1'b1, t0);
    hold(20);
    check("b2b pulses", 32'(qa.size()), 32'd3);
    check_next("b2b 00", 0, '{d: 8'h00, pe: 1'b0, fe: 1'b0}, t);
    check_next("b2b ff", 0, '{d: 8'hFF, pe: 1'b0, fe: 1'b0}, t);
    check_next("b2b 3c", 0, '{d: 8'h3C, pe: 1'b0, fe: 1'b0}, t);

    // Parity receiver, table-driven.
    for (int i = 0; i < 6; i++) begin
      send(1, tbl[i].d, 1, tbl[i].pbit, tbl[i].sbit, t0);
      rx_b = 1'b1;
      hold(20);
      check_next($sformatf("par vec%0d", i), 1,
                 '{d: tbl[i].exp_d, pe: tbl[i].exp_pe, fe: tbl[i].exp_fe}, t);
    end

    // Low stop bit followed by a long break: exactly one frame.
    send(0, 8'h55, 0, 1'b0, 1'b0, t0);
    hold(400);
    check("break pulses", 32'(qa.size()), 32'd1);
    check("break busy", 32'(busy_a), 32'd0);
    check_next("break frame", 0, '{d: 8'h55, pe: 1'b0, fe: 1'b1}, t);
    rx_a = 1'b1;
    hold(20);
    send(0, 8'hC3, 0, 1'b0, 1'b1, t0);
    hold(20);
    check_next("after break", 0, '{d: 8'hC3, pe: 1'b0, fe: 1'b0}, t);
    check("after break extra", 32'(qa.size()), 32'd0);
    last_a = '{d: 8'hC3, pe: 1'b0, fe: 1'b0};

    // Five-cycle glitch while idle.
    @(negedge clk);
    #1;
    t0 = ncount;
    rx_a = 1'b0;
    hold(5);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch busy c8", 32'(busy_a), 32'd1);
    @(negedge clk);
    check("glitch busy c9", 32'(busy_a), 32'd0);
    hold(200);
    check("glitch pulses", 32'(qa.size()), 32'd0);
    check("glitch outputs held", 32'({data_a, perr_a, ferr_a}), 32'(last_a));

    // Reset during data bit 4 of 0xFF.
    @(negedge clk);
    #1;
    rx_a = 1'b0;
    hold(16);
    rx_a = 1'b1;
    hold(69);
    check("pre-reset busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset outputs", {19'd0, data_a, done_a, busy_a, perr_a, ferr_a}, 32'd0);
    #1;
    reset = 1'b0;
    hold(200);
    check("midreset pulses", 32'(qa.size()), 32'd0);
    send(0, 8'h81, 0, 1'b0, 1'b1, t0);
    hold(20);
    check_next("after reset 81", 0, '{d: 8'h81, pe: 1'b0, fe: 1'b0}, t);

    // Randomized frames on both receivers against the frame model.
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send(0, d, 0, 1'b0, sb, t0);
      rx_a = 1'b1;
      hold(20 + $urandom_range(0, 10));
      e = model(d, 0, 1'b0, sb);
      check_next($sformatf("rand a%0d", i), 0, e, t);

      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      send(1, d, 1, pb, sb, t0);
      rx_b = 1'b1;
      hold(20 + $urandom_range(0, 10));
      e = model(d, 1, pb, sb);
      check_next($sformatf("rand b%0d", i), 1, e, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; the receive-side counterpart of the team's uart_tx on the Basys3 UART path.
- Runs on the same oversampled UART clock as uart_tx: each bit lasts OVERSAMPLE clk cycles.
- Detects the start bit, samples each bit at mid-point, and reassembles LSB-first data into a parallel word.
- Checks the parity and stop bits, then presents the word with a one-cycle done strobe.

Parameters:
- FRAME_BITS, 8: data bits per frame.
- PARITY_BIT, 2: 0 or 1 enables the parity bit; 2 disables it.
- STOP_BITS, 1: number of stop bits checked.
- OVERSAMPLE, 16: clk cycles per bit. Must be even and at least 4. Equals the transmitter's RETENTION_DURATION+1.

Ports:
- clk  input  1  UART oversampling clock.
- reset  input  1  Synchronous, active-high reset.
- rx  input  1  Serial line, asynchronous to clk, idle high.
- data  output  FRAME_BITS  Last received word; data[0] is the first bit received.
- rx_done  output  1  One-cycle pulse; data and the error flags are valid from this cycle.
- rx_busy  output  1  High while a frame is being received.
- parity_error  output  1  Parity mismatch on the last frame.
- framing_error  output  1  A stop bit sampled low on the last frame.

Behaviour:
- Reset (synchronous, checked on posedge clk):
  - state goes to IDLE.
  - data=0, rx_done=0, rx_busy=0, parity_error=0, framing_error=0.
  - Both synchronizer flops reset to 1. armed=1. Counters cleared.
  - A reset mid-frame abandons the frame with no rx_done.
- Synchronizer: rx passes through two flops to give rx_s. All decisions use rx_s, which lags the rx pin by 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - rx_busy=0.
  - If rx_s==1, set armed=1.
  - If armed and rx_s==0, go to START with cnt=0. Call this cycle 0.
- START:
  - cnt increments every cycle.
  - When cnt==OVERSAMPLE/2-1 (cycle 8 for defaults), check rx_s:
    - rx_s==0: go to DATA with cnt=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE. No rx_done, flags unchanged.
- DATA:
  - cnt counts 0..OVERSAMPLE-1. At cnt==OVERSAMPLE-1, shift rx_s into the shift register from the MSB side so the first received bit ends up in data[0]; then bit_idx++ and cnt=0.
  - Bit k is sampled at cycle OVERSAMPLE/2 + OVERSAMPLE*(k+1).
  - After FRAME_BITS samples, go to PARITY if PARITY_BIT<2, otherwise to STOP.
- PARITY:
  - One bit time. Store par_err = (sample != XOR of the received data bits).
  - The same even-sum check applies for PARITY_BIT 0 and 1, matching uart_tx.
- STOP:
  - STOP_BITS bit times, each sampled at cnt==OVERSAMPLE-1.
  - Any low sample sets fr_err. Sampling continues to the last stop bit.
- DONE, one cycle:
  - Load data from the shift register, rx_done=1.
  - parity_error=par_err (0 when parity is disabled). framing_error=fr_err.
  - If fr_err, set armed=0.
  - Return to IDLE.
- rx_busy is high in START, DATA, PARITY, STOP and DONE.
- data and both error flags hold until the next DONE.
- 8N1 defaults: stop bit sampled at cycle 152; rx_done high at cycle 153.
- Back-to-back frames: the FSM returns to IDLE mid-stop-bit and accepts the next falling edge immediately.
- Break or stuck-low line:
  - After a framing error, armed=0 prevents re-triggering until rx_s has been seen high.
  - A line held low therefore produces exactly one frame with framing_error=1.
- Counters: cnt is clog2(OVERSAMPLE) bits and wraps to 0 explicitly, never by overflow. bit_idx is clog2(FRAME_BITS)+1 bits.

Decomposition:
- Shared package uart_pkg holds:
  - The state encoding constants.
  - The frame-length function (1+FRAME_BITS+parity+STOP_BITS), shared with uart_tx.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with a reset value of 1.
- Everything else stays in uart_rx.

Test Plan:
- 8N1 frame for 0xA5, driven as 16 cycles per bit (bit order 1,0,1,0,0,1,0,1) -> rx_done pulses once, data=0xA5, both flags 0, rx_done at cycle 153 after rx_s first goes low.
- uart_tx (RETENTION_DURATION=15) looped into uart_rx, sending 0x00, 0xFF, 0x3C back-to-back -> three rx_done pulses with matching data and no errors.
- PARITY_BIT=0, 0x07 sent with parity bit 1 -> parity_error=0. Same frame with parity bit 0 -> parity_error=1, data=0x07.
- 0x55 sent with the stop bit low, then rx held low for 400 cycles, then high -> exactly one rx_done with framing_error=1. No further frames until rx returns high, then the next frame is received normally.
- rx low pulse of 5 cycles while idle -> no rx_done, rx_busy drops at cycle 9, flags unchanged.
- reset asserted during DATA bit 4 -> next cycle rx_busy=0 and all outputs 0; the following full frame 0x81 is received correctly.
